// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-read register file with x0 hardwired to zero.
// Provides write-to-read bypass, a per-register busy scoreboard and a registered debug tap.
module reg_file_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]            rbusy,
    input  logic                         issue_valid,
    input  logic [ADDR_WIDTH-1:0]        issue_rd,
    input  logic                         sb_flush,
    output logic                         any_busy,
    input  logic [ADDR_WIDTH-1:0]        dbg_addr,
    output logic [DATA_WIDTH-1:0]        dbg_data,
    output logic [DATA_WIDTH-1:0]        a0
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;
    logic [DATA_WIDTH-1:0] dbg_q;

    logic wr_en;
    logic iss_en;

    // x0 writes and x0 issues are dropped up front
    assign wr_en  = we && (waddr != '0);
    assign iss_en = issue_valid && (issue_rd != '0);

    // Architectural registers; entry 0 stays at its reset value forever
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Scoreboard next state: clear on writeback, set on issue (set wins), flush beats all
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[waddr] = 1'b0;
        end
        if (iss_en) begin
            busy_d[issue_rd] = 1'b1;
        end
        if (sb_flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Debug tap samples the stored value, so a same-cycle write is not visible yet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_q <= '0;
        end else begin
            dbg_q <= regs_q[dbg_addr];
        end
    end

    // Independent read ports with same-cycle bypass from the writeback bus
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  nz;
        logic                  hit;

        assign ra  = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign nz  = (ra != '0);
        assign hit = we && (waddr == ra);

        assign rdata[i*DATA_WIDTH +: DATA_WIDTH] =
            !nz ? '0 : (hit ? wdata : regs_q[ra]);

        // A value arriving this cycle is already usable through the bypass
        assign rbusy[i] = busy_q[ra] & ~hit & nz;
    end

    assign any_busy = |busy_q;
    assign dbg_data = dbg_q;
    assign a0       = regs_q[10];

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed self-checking bench for reg_file_mp.
// Three read ports; inputs change on negedge, outputs sampled 1ns later.
module tb_reg_file_mp;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rbusy;
    logic              issue_valid;
    logic [AW-1:0]     issue_rd;
    logic              sb_flush;
    logic              any_busy;
    logic [AW-1:0]     dbg_addr;
    logic [DW-1:0]     dbg_data;
    logic [DW-1:0]     a0;

    int errs   = 0;
    int checks = 0;

    logic [DW-1:0] rd0, rd1, rd2;
    assign rd0 = rdata[0*DW +: DW];
    assign rd1 = rdata[1*DW +: DW];
    assign rd2 = rdata[2*DW +: DW];

    reg_file_mp #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_RD     (NR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .raddr       (raddr),
        .rdata       (rdata),
        .rbusy       (rbusy),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .sb_flush    (sb_flush),
        .any_busy    (any_busy),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .a0          (a0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle;
        we          = 1'b0;
        issue_valid = 1'b0;
        sb_flush    = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] p0,
                          input logic [AW-1:0] p1,
                          input logic [AW-1:0] p2);
        raddr = {p2, p1, p0};
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        step();
        we    = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        we          = 1'b0;
        waddr       = '0;
        wdata       = '0;
        raddr       = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        sb_flush    = 1'b0;
        dbg_addr    = '0;

        // Power-on reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        set_rd(5'd5, 5'd10, 5'd31);
        #1;
        check("rst_rd0", rd0, 32'h0);
        check("rst_rd2", rd2, 32'h0);
        check("rst_any_busy", {31'b0, any_busy}, 32'h0);
        check("rst_dbg", dbg_data, 32'h0);
        check("rst_a0", a0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write x5 and mark it busy, then reset between edges
        we          = 1'b1;
        waddr       = 5'd5;
        wdata       = 32'hDEADBEEF;
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        set_rd(5'd5, 5'd0, 5'd0);
        step();
        idle();
        #1;
        check("x5_written", rd0, 32'hDEADBEEF);
        check("x5_busy", {31'b0, rbusy[0]}, 32'h1);
        check("x5_any_busy", {31'b0, any_busy}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rd0", rd0, 32'h0);
        check("midrst_rbusy", {31'b0, rbusy[0]}, 32'h0);
        check("midrst_any", {31'b0, any_busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst_rd0", rd0, 32'h0);

        // x0 protection: write and issue to x0 are dropped
        @(negedge clk);
        we          = 1'b1;
        waddr       = 5'd0;
        wdata       = 32'h12345678;
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        set_rd(5'd0, 5'd0, 5'd0);
        #1;
        check("x0_byp_rd0", rd0, 32'h0);
        check("x0_byp_rd1", rd1, 32'h0);
        check("x0_byp_rd2", rd2, 32'h0);
        step();
        idle();
        #1;
        check("x0_rd0", rd0, 32'h0);
        check("x0_rbusy", {29'b0, rbusy}, 32'h0);
        check("x0_any_busy", {31'b0, any_busy}, 32'h0);

        // Same-cycle bypass then stored value
        @(negedge clk);
        we    = 1'b1;
        waddr = 5'd7;
        wdata = 32'hA5A5A5A5;
        set_rd(5'd7, 5'd0, 5'd0);
        #1;
        check("byp_x7", rd0, 32'hA5A5A5A5);
        step();
        idle();
        #1;
        check("held_x7", rd0, 32'hA5A5A5A5);

        // Scoreboard set on issue, cleared on writeback
        @(negedge clk);
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        set_rd(5'd3, 5'd0, 5'd0);
        #1;
        check("x3_not_yet", {31'b0, rbusy[0]}, 32'h0);
        step();
        idle();
        #1;
        check("x3_busy", {31'b0, rbusy[0]}, 32'h1);
        check("x3_any", {31'b0, any_busy}, 32'h1);
        we    = 1'b1;
        waddr = 5'd3;
        wdata = 32'h33;
        #1;
        check("x3_wb_rbusy", {31'b0, rbusy[0]}, 32'h0);
        check("x3_wb_data", rd0, 32'h33);
        step();
        idle();
        #1;
        check("x3_clr_rbusy", {31'b0, rbusy[0]}, 32'h0);
        check("x3_clr_any", {31'b0, any_busy}, 32'h0);

        // Issue and writeback of same register: set wins
        @(negedge clk);
        issue_valid = 1'b1;
        issue_rd    = 5'd4;
        we          = 1'b1;
        waddr       = 5'd4;
        wdata       = 32'h44;
        set_rd(5'd4, 5'd8, 5'd9);
        step();
        idle();
        #1;
        check("x4_set_wins", {31'b0, rbusy[0]}, 32'h1);
        check("x4_data", rd0, 32'h44);

        // Issue x8 while clearing x4: both take effect
        issue_valid = 1'b1;
        issue_rd    = 5'd8;
        we          = 1'b1;
        waddr       = 5'd4;
        wdata       = 32'h45;
        step();
        idle();
        #1;
        check("x4_cleared", {31'b0, rbusy[0]}, 32'h0);
        check("x8_busy", {31'b0, rbusy[1]}, 32'h1);

        // Second issue to a busy register keeps it busy
        issue_valid = 1'b1;
        issue_rd    = 5'd8;
        step();
        idle();
        #1;
        check("x8_still_busy", {31'b0, rbusy[1]}, 32'h1);

        // Flush overrides a same-cycle issue
        sb_flush    = 1'b1;
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        step();
        idle();
        #1;
        check("flush_rbusy", {29'b0, rbusy}, 32'h0);
        check("flush_any", {31'b0, any_busy}, 32'h0);

        // Three independent read ports
        wr(5'd1, 32'h1);
        wr(5'd2, 32'h2);
        wr(5'd31, 32'hFFFFFFFF);
        set_rd(5'd1, 5'd2, 5'd31);
        #1;
        check("mp_rd0", rd0, 32'h1);
        check("mp_rd1", rd1, 32'h2);
        check("mp_rd2", rd2, 32'hFFFFFFFF);
        set_rd(5'd2, 5'd2, 5'd2);
        #1;
        check("mp_same_rd0", rd0, 32'h2);
        check("mp_same_rd2", rd2, 32'h2);

        // Debug tap: one cycle latency, pre-write contents in a write cycle
        dbg_addr = 5'd31;
        step();
        #1;
        check("dbg_x31", dbg_data, 32'hFFFFFFFF);
        wr(5'd31, 32'h77);
        #1;
        check("dbg_prewrite", dbg_data, 32'hFFFFFFFF);
        step();
        #1;
        check("dbg_postwrite", dbg_data, 32'h77);

        // a0 follows x10 after the write lands
        we    = 1'b1;
        waddr = 5'd10;
        wdata = 32'h55;
        #1;
        check("a0_before", a0, 32'h0);
        step();
        idle();
        #1;
        check("a0_after", a0, 32'h55);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor to the single-write, two-read register file for the RV32I core.
- Generalised in data width, address width and read-port count. Adds:
  - hardwired-zero x0;
  - asynchronous active-low reset of all architectural state;
  - write-to-read bypass;
  - a per-register busy scoreboard for the pipelined datapath.
- Sits between the decode stage (reads, issue) and the writeback stage (write, scoreboard clear).

Parameters:
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register data width.
- NUM_RD, 2, number of read ports (1..4).

Ports:
- Interface convention: one clock, clk; reset is asynchronous and active-low, rst_n.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  writeback enable.
- waddr  in  ADDR_WIDTH  writeback register index.
- wdata  in  DATA_WIDTH  writeback data.
- raddr  in  NUM_RD*ADDR_WIDTH  read indices; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NUM_RD*DATA_WIDTH  read data; packed in the same way as raddr.
- rbusy  out  NUM_RD  per-port flag: the source register has an outstanding producer.
- issue_valid  in  1  decode issues an instruction that will write issue_rd.
- issue_rd  in  ADDR_WIDTH  destination register of the issued instruction.
- sb_flush  in  1  synchronous clear of all busy bits (pipeline flush).
- any_busy  out  1  OR of all busy bits.
- dbg_addr  in  ADDR_WIDTH  debug tap select.
- dbg_data  out  DATA_WIDTH  registered copy of regfile[dbg_addr]; not bypassed.
- a0  out  DATA_WIDTH  combinational regfile[10], for the testbench.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all NUM_REGS registers clear to 0;
  - all busy bits clear to 0;
  - dbg_data clears to 0.
  - Consequently rdata = 0, rbusy = 0, any_busy = 0, a0 = 0 while reset is held.
  - Assertion mid-operation aborts any in-flight write.
  - Deassertion is synchronised externally; first update occurs on the first posedge with rst_n high.
- Write: on posedge, if we and waddr != 0, regfile[waddr] <= wdata. Writes to x0 are discarded.
- x0: always reads 0 on every port; its busy bit is never set.
- Read, combinational, per port i:
  - if raddr_i == 0: 0;
  - else if we and waddr == raddr_i: wdata (same-cycle bypass);
  - else regfile[raddr_i].
  - All ports are independent; identical addresses on several ports are legal.
- Scoreboard: busy[NUM_REGS-1:1] flops. Per posedge, in this priority order:
  1. sb_flush: all busy <= 0. Overrides issue and writeback in the same cycle.
  2. issue_valid and issue_rd != 0: busy[issue_rd] <= 1.
  3. we and waddr != 0: busy[waddr] <= 0, unless the same register is set by rule 2 in the same cycle (set wins: a new producer supersedes).
- Issue and clear of different registers in the same cycle both take effect.
- rbusy_i = busy[raddr_i] AND NOT (we and waddr == raddr_i) AND (raddr_i != 0). The value being written this cycle is already available through the bypass.
- Scoreboard is one-deep per register: a second issue to a busy register leaves it busy. Ordering is the pipeline's responsibility.
- dbg_data <= regfile[dbg_addr] each posedge, giving 1-cycle latency; it reflects pre-write contents in a write cycle.
- No X propagation: every register has a defined reset value.

Test Plan:
- Reset: write 0xDEADBEEF to x5, assert rst_n low between clock edges → rdata for raddr=5 is 0 immediately; rbusy=0; any_busy=0.
- x0 protection: we=1, waddr=0, wdata=0x12345678, then read raddr=0 on all ports → 0; any_busy stays 0 after issue_rd=0.
- Bypass:
  - we=1, waddr=7, wdata=0xA5A5A5A5, port0 raddr=7 in the same cycle → rdata0 = 0xA5A5A5A5 before the edge;
  - next cycle without we → still 0xA5A5A5A5.
- Scoreboard set/clear:
  - issue x3 → next cycle rbusy0=1 for raddr=3;
  - writeback x3 → rbusy0=0 in the write cycle (bypass) and after the edge; any_busy returns to 0.
- Simultaneous events:
  - issue_rd=4 and we/waddr=4 in the same cycle → busy[4]=1 after the edge;
  - sb_flush with issue_rd=9 → busy all 0.
- Multi-port/debug, NUM_RD=3:
  - registers x1=1, x2=2, x31=0xFFFFFFFF; raddr={31,2,1} → rdata={0xFFFFFFFF,2,1};
  - dbg_addr=31 → dbg_data=0xFFFFFFFF one cycle later;
  - a0 tracks x10 after a write of 0x55.
